fas_peak_scheduler: RTL and testbench
=====================================

# fas_peak_scheduler

Frame-level controller behind the FIR/FFT analysis datapath. It detects each new 16-bin FFT frame, snapshots it, and time-multiplexes one squared-magnitude unit across the bins, one bin per cycle. It tracks the spectral peak and reports it on `done`/`freq`. A one-deep shadow buffer absorbs a frame that arrives while a scan is running; further frames are flagged as overruns.

## Interface
- `SKIP_DC`, default 0: when 1, bin 0 is excluded from the peak search.
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `fft_valid`  in  1  level flag from the FFT stage; a new frame is its rising edge
- `fft_flat`  in  512  bin k at [32k+31:32k]; {re[31:16], im[15:0]}, signed 16-bit each
- `busy`  out  1  high while a scan is in progress
- `done`  out  1  one-cycle pulse when a scan result is valid
- `freq`  out  4  bin index of the peak; held until the next `done`
- `peak_mag`  out  32  re²+im² of the peak bin, unsigned; held with `freq`
- `overrun`  out  1  sticky; set when a frame is dropped, cleared only by `rst`

## Operation
- Edge detect: `frame_evt = fft_valid & ~fft_valid_q`. A level held high for many cycles yields exactly one frame.
- States: IDLE, SCAN.
- IDLE:
  - On `frame_evt`: load `fft_flat` into the main buffer.
  - Set idx=0 (idx=1 if SKIP_DC), max_mag=0, max_idx=idx; go to SCAN.
- SCAN, each cycle:
  - mag = re[idx]² + im[idx]², computed as 32-bit unsigned. The maximum value 0x80000000, from (-32768,-32768), must not overflow.
  - The first scanned bin always loads max_mag/max_idx.
  - Later bins update only if mag > max_mag (strict). Ties therefore keep the lower index.
  - idx increments each cycle.
- Last bin (idx=15):
  - Register `done`=1, `freq`=final max_idx and `peak_mag`=final max_mag, including bin 15 in the comparison.
  - If pending: copy shadow to main, clear pending, restart SCAN.
  - Otherwise: go to IDLE.
- `frame_evt` during SCAN:
  - If no frame is pending: capture into the shadow buffer and set pending.
  - If a frame is already pending: overwrite the shadow (newest frame wins) and set `overrun`.
- Simultaneous `frame_evt` and last-bin cycle, no pending: capture into the shadow and set pending. The current scan reports normally.
- Simultaneous `frame_evt` and last-bin cycle, pending set:
  - The old shadow moves to main.
  - The new frame goes to the shadow; pending stays set.
  - No overrun.
- All-zero frame: `freq`=0, or 1 if SKIP_DC; `peak_mag`=0.

## Timing
- Reset (`rst` high at an edge):
  - State IDLE; buffers, pending and `fft_valid_q` cleared.
  - `busy`, `done`, `overrun`, `freq` and `peak_mag` all 0.
- `rst` mid-scan aborts with no `done`.
- Latency: edge E0 samples `frame_evt`; scan edges E1..E16 (E1..E15 with SKIP_DC).
  - `done` is high in the cycle after the last scan edge: 16 cycles after E0, or 15 with SKIP_DC.
- `busy` is high from the cycle after E0 through the cycle of the last scan edge. It stays high across a pending restart.
- Back-to-back: with pending set, the next scan starts on the edge that raises `done`. The second `done` follows the first by exactly 16 cycles.
- All outputs are registered; nothing is combinational from inputs.

## Structure
- Shared package `fas_pkg`:
  - NBINS=16, BIN_W=16, MAG_W=32.
  - State enum {IDLE, SCAN}.
  - Bin-slice helper function.
- Sub-module `fas_mag_sq`: combinational re²+im², 16-bit signed in, 32-bit unsigned out. Exactly one instance (the shared resource).
- Top contains the edge detect, both buffers, the FSM, the comparator and the output registers.

## Test plan
- Single peak: bin 5 = {re=100, im=0}, others 0, `fft_valid` rises and stays high.
  - Expect one `done` 16 cycles later, `freq`=5, `peak_mag`=10000, and no second `done`.
- Tie: bins 3 and 9 = {-200, 0}, others {1, 1}.
  - Expect `freq`=3, `peak_mag`=40000.
- Extreme value: bin 12 = {-32768, -32768}, bin 0 = {32767, 0}.
  - Expect `freq`=12, `peak_mag`=0x80000000.
- Back-to-back frames:
  - Frame A (peak bin 2) at E0; frame B (peak bin 7) rising at E8.
  - Expect `done` at E0+16 with `freq`=2, then `done` at E0+32 with `freq`=7, and `busy` continuous.
  - Add frame C (peak bin 11) at E12: expect `overrun`=1 and the second result `freq`=11.
- Reset mid-scan: assert `rst` for 1 cycle at scan cycle 10.
  - Expect no `done`, all outputs 0 and `busy`=0.
  - A subsequent frame reports normally.
- SKIP_DC=1: bin 0 = {30000, 0}, bin 4 = {50, 50}.
  - Expect `freq`=4, `peak_mag`=5000, `done` 15 cycles after the edge.

Source files
------------

// File: rtl/fas_pkg.sv
// Shared types and constants for the FFT peak scheduler.
// bin_slice pulls one {re, im} word out of a flattened 16-bin frame.
package fas_pkg;

    localparam int NBINS   = 16;
    localparam int BIN_W   = 16;
    localparam int MAG_W   = 32;
    localparam int IDX_W   = 4;
    localparam int WORD_W  = 2 * BIN_W;
    localparam int FRAME_W = NBINS * WORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    function automatic logic [WORD_W-1:0] bin_slice(
        input logic [FRAME_W-1:0] frame,
        input logic [IDX_W-1:0]   k
    );
        return frame[{k, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude of one signed bin.
// (-32768)^2 * 2 = 2^31, so the sum always fits in 32 unsigned bits.
module fas_mag_sq
    import fas_pkg::*;
(
    input  logic signed [BIN_W-1:0] re,
    input  logic signed [BIN_W-1:0] im,
    output logic        [MAG_W-1:0] mag
);

    logic signed [MAG_W-1:0] re_ext;
    logic signed [MAG_W-1:0] im_ext;
    logic signed [MAG_W-1:0] re_sq;
    logic signed [MAG_W-1:0] im_sq;

    assign re_ext = MAG_W'(re);
    assign im_ext = MAG_W'(im);
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    assign mag    = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_peak_scheduler.sv
// Frame scheduler: snapshots each FFT frame and scans one bin per cycle for the peak.
// state | meaning
// IDLE  | waiting for a frame edge (or a frame left pending by the previous scan)
// SCAN  | squaring main_buf[idx] and updating the running maximum
module fas_peak_scheduler
    import fas_pkg::*;
#(
    parameter bit SKIP_DC = 1'b0
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               fft_valid,
    input  logic [FRAME_W-1:0] fft_flat,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   freq,
    output logic [MAG_W-1:0]   peak_mag,
    output logic               overrun
);

    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(SKIP_DC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBINS - 1);

    state_t             state;
    state_t             state_next;
    logic               fft_valid_q;
    logic               frame_evt;
    logic [FRAME_W-1:0] main_buf;
    logic [FRAME_W-1:0] shadow_buf;
    logic               pending;
    logic               pending_next;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   max_idx;
    logic [MAG_W-1:0]   max_mag;

    logic [WORD_W-1:0]  bin_word;
    logic [MAG_W-1:0]   mag;
    logic               take;
    logic [MAG_W-1:0]   cand_mag;
    logic [IDX_W-1:0]   cand_idx;
    logic               last_bin;

    logic               start_from_in;
    logic               start_from_shadow;
    logic               capture_shadow;
    logic               set_overrun;
    logic               report;

    assign frame_evt = fft_valid & ~fft_valid_q;
    assign bin_word  = bin_slice(main_buf, idx);

    fas_mag_sq u_mag_sq (
        .re  (bin_word[WORD_W-1:BIN_W]),
        .im  (bin_word[BIN_W-1:0]),
        .mag (mag)
    );

    // First scanned bin always seeds the maximum; strict compare keeps the lower index on ties.
    assign take     = (idx == IDX_FIRST) || (mag > max_mag);
    assign cand_mag = take ? mag : max_mag;
    assign cand_idx = take ? idx : max_idx;
    assign last_bin = (state == SCAN) && (idx == IDX_LAST);
    assign busy     = (state == SCAN);

    always_comb begin
        state_next        = state;
        pending_next      = pending;
        start_from_in     = 1'b0;
        start_from_shadow = 1'b0;
        capture_shadow    = 1'b0;
        set_overrun       = 1'b0;
        report            = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    start_from_shadow = 1'b1;
                    state_next        = SCAN;
                    if (frame_evt) capture_shadow = 1'b1;
                    else           pending_next   = 1'b0;
                end else if (frame_evt) begin
                    start_from_in = 1'b1;
                    state_next    = SCAN;
                end
            end
            SCAN: begin
                if (last_bin) begin
                    report = 1'b1;
                    if (pending) begin
                        // Old shadow moves to main while a new frame refills the shadow.
                        start_from_shadow = 1'b1;
                        if (frame_evt) capture_shadow = 1'b1;
                        else           pending_next   = 1'b0;
                    end else begin
                        state_next = IDLE;
                        if (frame_evt) begin
                            capture_shadow = 1'b1;
                            pending_next   = 1'b1;
                        end
                    end
                end else if (frame_evt) begin
                    capture_shadow = 1'b1;
                    pending_next   = 1'b1;
                    set_overrun    = pending;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fft_valid_q <= 1'b0;
            main_buf    <= '0;
            shadow_buf  <= '0;
            pending     <= 1'b0;
            idx         <= '0;
            max_idx     <= '0;
            max_mag     <= '0;
            done        <= 1'b0;
            freq        <= '0;
            peak_mag    <= '0;
            overrun     <= 1'b0;
        end else begin
            state       <= state_next;
            fft_valid_q <= fft_valid;
            pending     <= pending_next;
            done        <= report;
            if (report) begin
                freq     <= cand_idx;
                peak_mag <= cand_mag;
            end
            if (set_overrun)    overrun    <= 1'b1;
            if (capture_shadow) shadow_buf <= fft_flat;
            if (start_from_in)          main_buf <= fft_flat;
            else if (start_from_shadow) main_buf <= shadow_buf;
            if (start_from_in || start_from_shadow) begin
                idx     <= IDX_FIRST;
                max_idx <= IDX_FIRST;
                max_mag <= '0;
            end else if (state == SCAN) begin
                idx     <= idx + 1'b1;
                max_idx <= cand_idx;
                max_mag <= cand_mag;
            end
        end
    end

endmodule

// File: tb/tb_fas_peak_scheduler.sv
// Directed bench for fas_peak_scheduler: one DUT with SKIP_DC=0 and one with SKIP_DC=1
// share the same inputs; expected values are hand-computed per scenario.
module tb_fas_peak_scheduler;

    logic         clk;
    logic         rst;
    logic         fft_valid;
    logic [511:0] fft_flat;

    logic         busy0, done0, overrun0;
    logic [3:0]   freq0;
    logic [31:0]  mag0;
    logic         busy1, done1, overrun1;
    logic [3:0]   freq1;
    logic [31:0]  mag1;

    int checks;
    int failures;

    fas_peak_scheduler #(.SKIP_DC(1'b0)) dut0 (
        .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_flat(fft_flat),
        .busy(busy0), .done(done0), .freq(freq0), .peak_mag(mag0), .overrun(overrun0)
    );

    fas_peak_scheduler #(.SKIP_DC(1'b1)) dut1 (
        .clk(clk), .rst(rst), .fft_valid(fft_valid), .fft_flat(fft_flat),
        .busy(busy1), .done(done1), .freq(freq1), .peak_mag(mag1), .overrun(overrun1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] put_bin(input logic [511:0] f, input int k,
                                             input logic [15:0] re, input logic [15:0] im);
        logic [511:0] r;
        r = f;
        r[32*k +: 32] = {re, im};
        return r;
    endfunction

    // Raises fft_valid (held high for ncyc cycles) and records the first done of each DUT.
    // Sample n is taken at the falling edge after edge E(n), E0 being the edge that sees the rise.
    task automatic send_frame(input logic [511:0] f, input int ncyc,
                              output int lat0, output int nd0, output logic [3:0] fq0, output logic [31:0] mg0,
                              output int lat1, output int nd1, output logic [3:0] fq1, output logic [31:0] mg1);
        @(negedge clk);
        fft_flat  = f;
        fft_valid = 1'b1;
        lat0 = -1; nd0 = 0; fq0 = '0; mg0 = '0;
        lat1 = -1; nd1 = 0; fq1 = '0; mg1 = '0;
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) begin
                if (lat0 < 0) begin lat0 = n; fq0 = freq0; mg0 = mag0; end
                nd0++;
            end
            if (done1) begin
                if (lat1 < 0) begin lat1 = n; fq1 = freq1; mg1 = mag1; end
                nd1++;
            end
        end
        fft_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fft_valid = 1'b0;
        fft_flat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy0 !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %0b expected 0", busy0); end
        checks++; if (done0 !== 1'b0)      begin failures++; $display("FAIL reset_done: got %0b expected 0", done0); end
        checks++; if (overrun0 !== 1'b0)   begin failures++; $display("FAIL reset_overrun: got %0b expected 0", overrun0); end
        checks++; if (freq0 !== 4'd0)      begin failures++; $display("FAIL reset_freq: got %0d expected 0", freq0); end
        checks++; if (mag0 !== 32'd0)      begin failures++; $display("FAIL reset_peak_mag: got %0d expected 0", mag0); end
    endtask

    task automatic test_single_peak();
        logic [511:0] f;
        int l0, n0, l1, n1;
        logic [3:0] q0, q1;
        logic [31:0] m0, m1;
        f = '0;
        f = put_bin(f, 5, 16'd100, 16'd0);
        send_frame(f, 40, l0, n0, q0, m0, l1, n1, q1, m1);
        checks++; if (l0 !== 16)        begin failures++; $display("FAIL single_latency: got %0d expected 16", l0); end
        checks++; if (n0 !== 1)         begin failures++; $display("FAIL single_done_count: got %0d expected 1", n0); end
        checks++; if (q0 !== 4'd5)      begin failures++; $display("FAIL single_freq: got %0d expected 5", q0); end
        checks++; if (m0 !== 32'd10000) begin failures++; $display("FAIL single_peak_mag: got %0d expected 10000", m0); end
        checks++; if (l1 !== 15)        begin failures++; $display("FAIL single_skipdc_latency: got %0d expected 15", l1); end
        checks++; if (q1 !== 4'd5)      begin failures++; $display("FAIL single_skipdc_freq: got %0d expected 5", q1); end
        checks++; if (busy0 !== 1'b0)   begin failures++; $display("FAIL single_busy_after: got %0b expected 0", busy0); end
    endtask

    task automatic test_tie();
        logic [511:0] f;
        int l0, n0, l1, n1;
        logic [3:0] q0, q1;
        logic [31:0] m0, m1;
        f = '0;
        for (int k = 0; k < 16; k++) f = put_bin(f, k, 16'd1, 16'd1);
        f = put_bin(f, 3, -16'sd200, 16'd0);
        f = put_bin(f, 9, -16'sd200, 16'd0);
        send_frame(f, 20, l0, n0, q0, m0, l1, n1, q1, m1);
        checks++; if (q0 !== 4'd3)      begin failures++; $display("FAIL tie_freq: got %0d expected 3", q0); end
        checks++; if (m0 !== 32'd40000) begin failures++; $display("FAIL tie_peak_mag: got %0d expected 40000", m0); end
    endtask

    task automatic test_extreme();
        logic [511:0] f;
        int l0, n0, l1, n1;
        logic [3:0] q0, q1;
        logic [31:0] m0, m1;
        f = '0;
        f = put_bin(f, 12, 16'h8000, 16'h8000);
        f = put_bin(f, 0, 16'd32767, 16'd0);
        send_frame(f, 20, l0, n0, q0, m0, l1, n1, q1, m1);
        checks++; if (q0 !== 4'd12)        begin failures++; $display("FAIL extreme_freq: got %0d expected 12", q0); end
        checks++; if (m0 !== 32'h80000000) begin failures++; $display("FAIL extreme_peak_mag: got %h expected 80000000", m0); end
    endtask

    task automatic test_all_zero();
        int l0, n0, l1, n1;
        logic [3:0] q0, q1;
        logic [31:0] m0, m1;
        send_frame('0, 20, l0, n0, q0, m0, l1, n1, q1, m1);
        checks++; if (q0 !== 4'd0)  begin failures++; $display("FAIL zero_freq: got %0d expected 0", q0); end
        checks++; if (m0 !== 32'd0) begin failures++; $display("FAIL zero_peak_mag: got %0d expected 0", m0); end
        checks++; if (q1 !== 4'd1)  begin failures++; $display("FAIL zero_skipdc_freq: got %0d expected 1", q1); end
        checks++; if (m1 !== 32'd0) begin failures++; $display("FAIL zero_skipdc_peak_mag: got %0d expected 0", m1); end
    endtask

    task automatic test_skip_dc();
        logic [511:0] f;
        int l0, n0, l1, n1;
        logic [3:0] q0, q1;
        logic [31:0] m0, m1;
        f = '0;
        f = put_bin(f, 0, 16'd30000, 16'd0);
        f = put_bin(f, 4, 16'd50, 16'd50);
        send_frame(f, 20, l0, n0, q0, m0, l1, n1, q1, m1);
        checks++; if (l1 !== 15)            begin failures++; $display("FAIL skipdc_latency: got %0d expected 15", l1); end
        checks++; if (q1 !== 4'd4)          begin failures++; $display("FAIL skipdc_freq: got %0d expected 4", q1); end
        checks++; if (m1 !== 32'd5000)      begin failures++; $display("FAIL skipdc_peak_mag: got %0d expected 5000", m1); end
        checks++; if (q0 !== 4'd0)          begin failures++; $display("FAIL skipdc_off_freq: got %0d expected 0", q0); end
        checks++; if (m0 !== 32'd900000000) begin failures++; $display("FAIL skipdc_off_peak_mag: got %0d expected 900000000", m0); end
    endtask

    task automatic test_back_to_back(input bit with_c);
        logic [511:0] fa, fb, fc;
        int d1, d2, nd;
        logic [3:0] f1, f2;
        logic busy_gap;
        int exp_f2;
        fa = put_bin('0, 2, 16'd1000, 16'd0);
        fb = put_bin('0, 7, 16'd1000, 16'd0);
        fc = put_bin('0, 11, 16'd1000, 16'd0);
        exp_f2 = with_c ? 11 : 7;
        @(negedge clk);
        fft_flat  = fa;
        fft_valid = 1'b1;
        d1 = -1; d2 = -1; nd = 0; f1 = '0; f2 = '0; busy_gap = 1'b0;
        for (int n = 0; n < 48; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) begin
                nd++;
                if (d1 < 0)      begin d1 = n; f1 = freq0; end
                else if (d2 < 0) begin d2 = n; f2 = freq0; end
            end
            if (n < 32 && !busy0) busy_gap = 1'b1;
            if (n == 2 || n == 9 || n == 13) fft_valid = 1'b0;
            if (n == 7) begin fft_flat = fb; fft_valid = 1'b1; end
            if (n == 11 && with_c) begin fft_flat = fc; fft_valid = 1'b1; end
        end
        checks++; if (d1 !== 16)       begin failures++; $display("FAIL b2b_first_done: got %0d expected 16 (c=%0b)", d1, with_c); end
        checks++; if (f1 !== 4'd2)     begin failures++; $display("FAIL b2b_first_freq: got %0d expected 2 (c=%0b)", f1, with_c); end
        checks++; if (d2 !== 32)       begin failures++; $display("FAIL b2b_second_done: got %0d expected 32 (c=%0b)", d2, with_c); end
        checks++; if (f2 !== 4'(exp_f2)) begin failures++; $display("FAIL b2b_second_freq: got %0d expected %0d", f2, exp_f2); end
        checks++; if (nd !== 2)        begin failures++; $display("FAIL b2b_done_count: got %0d expected 2 (c=%0b)", nd, with_c); end
        checks++; if (busy_gap !== 1'b0) begin failures++; $display("FAIL b2b_busy_continuous: got gap=%0b expected 0 (c=%0b)", busy_gap, with_c); end
        checks++; if (overrun0 !== with_c) begin failures++; $display("FAIL b2b_overrun: got %0b expected %0b", overrun0, with_c); end
    endtask

    task automatic test_reset_mid_scan();
        logic [511:0] f;
        int nd;
        logic busy_mid;
        int l0, n0, l1, n1;
        logic [3:0] q0, q1;
        logic [31:0] m0, m1;
        f = put_bin('0, 5, 16'd100, 16'd0);
        @(negedge clk);
        fft_flat  = f;
        fft_valid = 1'b1;
        nd = 0;
        busy_mid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) nd++;
            if (n == 5) busy_mid = busy0;
            if (n == 2) fft_valid = 1'b0;
            if (n == 9) rst = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy_mid !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before: got %0b expected 1", busy_mid); end
        checks++; if (busy0 !== 1'b0)    begin failures++; $display("FAIL rstmid_busy: got %0b expected 0", busy0); end
        checks++; if (freq0 !== 4'd0)    begin failures++; $display("FAIL rstmid_freq: got %0d expected 0", freq0); end
        checks++; if (mag0 !== 32'd0)    begin failures++; $display("FAIL rstmid_peak_mag: got %0d expected 0", mag0); end
        checks++; if (overrun0 !== 1'b0) begin failures++; $display("FAIL rstmid_overrun: got %0b expected 0", overrun0); end
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done0) nd++;
        end
        checks++; if (nd !== 0) begin failures++; $display("FAIL rstmid_no_done: got %0d expected 0", nd); end
        send_frame(f, 20, l0, n0, q0, m0, l1, n1, q1, m1);
        checks++; if (l0 !== 16)        begin failures++; $display("FAIL rstmid_after_latency: got %0d expected 16", l0); end
        checks++; if (q0 !== 4'd5)      begin failures++; $display("FAIL rstmid_after_freq: got %0d expected 5", q0); end
        checks++; if (m0 !== 32'd10000) begin failures++; $display("FAIL rstmid_after_peak_mag: got %0d expected 10000", m0); end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_peak();
        test_tie();
        test_extreme();
        test_all_zero();
        test_skip_dc();
        test_back_to_back(1'b0);
        pulse_reset();
        test_back_to_back(1'b1);
        pulse_reset();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
